// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: iterative MULT/MULTU, restoring DIV/DIVU,
// HI/LO ownership for MFHI/MFLO/MTHI/MTLO, and the EX pipeline hold.
module ex_muldiv_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mdOpE,
  input  logic [WIDTH-1:0] srcAE,
  input  logic [WIDTH-1:0] srcBE,
  input  logic             flushE,
  output logic             stallE,
  output logic             busyE,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut
);

  localparam int MAX_CYC = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             signed_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             busy_reg;

  logic             issue_op;
  logic             div_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  assign issue_op   = (mdOpE >= OP_MULT) && (mdOpE <= OP_DIVU);
  assign div_signed = (mdOpE == OP_DIV);
  assign sign_a     = div_signed & srcAE[WIDTH-1];
  assign sign_b     = div_signed & srcBE[WIDTH-1];
  assign abs_a      = sign_a ? (~srcAE + WIDTH'(1)) : srcAE;
  assign abs_b      = sign_b ? (~srcBE + WIDTH'(1)) : srcBE;

  // Sign-extending to 2*WIDTH lets one unsigned multiply serve MULT and MULTU.
  assign ext_a   = {{WIDTH{signed_reg & a_reg[WIDTH-1]}}, a_reg};
  assign ext_b   = {{WIDTH{signed_reg & b_reg[WIDTH-1]}}, b_reg};
  assign product = ext_a * ext_b;

  // a_reg shifts dividend bits out the top and quotient bits in the bottom.
  assign shifted  = {rem_reg, a_reg[WIDTH-1]};
  assign trial    = shifted - {1'b0, b_reg};
  assign q_bit    = ~trial[WIDTH];
  assign rem_step = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {a_reg[WIDTH-2:0], q_bit};
  assign quo_fix  = neg_q_reg ? (~quo_step + WIDTH'(1)) : quo_step;
  assign rem_fix  = neg_r_reg ? (~rem_step + WIDTH'(1)) : rem_step;

  assign stallE = !flushE &&
                  (((state_reg == IDLE) && issue_op) ||
                   (state_reg == MUL) || (state_reg == DIV));
  assign busyE  = busy_reg;
  assign hiOut  = hi_reg;
  assign loOut  = lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      signed_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!flushE) begin
            case (mdOpE)
              OP_MULT, OP_MULTU: begin
                state_reg  <= MUL;
                busy_reg   <= 1'b1;
                count_reg  <= CW'(MUL_CYCLES);
                a_reg      <= srcAE;
                b_reg      <= srcBE;
                signed_reg <= (mdOpE == OP_MULT);
              end
              OP_DIV, OP_DIVU: begin
                state_reg  <= DIV;
                busy_reg   <= 1'b1;
                count_reg  <= CW'(WIDTH);
                a_reg      <= abs_a;
                b_reg      <= abs_b;
                rem_reg    <= '0;
                signed_reg <= div_signed;
                neg_q_reg  <= sign_a ^ sign_b;
                neg_r_reg  <= sign_a;
              end
              OP_MTHI: hi_reg <= srcAE;
              OP_MTLO: lo_reg <= srcAE;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flushE) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            count_reg <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
              {hi_reg, lo_reg} <= product;
              state_reg        <= DONE;
              busy_reg         <= 1'b0;
            end
          end
        end
        DIV: begin
          if (flushE) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            count_reg <= count_reg - CW'(1);
            a_reg     <= quo_step;
            rem_reg   <= rem_step;
            if (count_reg == CW'(1)) begin
              hi_reg    <= rem_fix;
              lo_reg    <= quo_fix;
              state_reg <= DONE;
              busy_reg  <= 1'b0;
            end
          end
        end
        // mdOpE still carries the finishing instruction here; ignoring it stops a re-issue.
        DONE: state_reg <= IDLE;
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: MT writes, multiply, divide corners,
// flush and reset aborts, and DONE-state re-issue suppression.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mdOpE;
  logic [31:0] srcAE;
  logic [31:0] srcBE;
  logic        flushE;
  logic        stallE;
  logic        busyE;
  logic [31:0] hiOut;
  logic [31:0] loOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.WIDTH(32), .MUL_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .mdOpE (mdOpE),
    .srcAE (srcAE),
    .srcBE (srcBE),
    .flushE(flushE),
    .stallE(stallE),
    .busyE (busyE),
    .hiOut (hiOut),
    .loOut (loOut)
  );

  // Divide vectors: DIV -7/2, DIVU 100/7, DIVU 5/0, DIV min/-1, DIV 7/-2, DIV -5/0
  logic [2:0]  div_op [6] = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3};
  logic [31:0] div_a  [6] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'd7, 32'hFFFFFFFB};
  logic [31:0] div_b  [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
  logic [31:0] div_hi [6] = '{32'hFFFFFFFF, 32'd2, 32'd5, 32'h0, 32'd1, 32'hFFFFFFFB};
  logic [31:0] div_lo [6] = '{32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'd1};

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Issues op at cycle 0, holds mdOpE through the DONE cycle (n+1), then drops it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, output int stall_cnt, output logic stall_done,
                        output logic busy_mid, output logic busy_after,
                        output logic [31:0] hi_o, output logic [31:0] lo_o);
    stall_cnt = 0;
    busy_mid  = 1'b0;
    stall_done = 1'bx;
    hi_o = 'x;
    lo_o = 'x;
    mdOpE = op;
    srcAE = a;
    srcBE = b;
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      if (stallE === 1'b1) stall_cnt++;
      if (c == 1) busy_mid = busyE;
      if (c == n + 1) begin
        stall_done = stallE;
        hi_o = hiOut;
        lo_o = loOut;
      end
      next_cycle();
      if (c == 0) begin
        srcAE = 32'hA5A55A5A;
        srcBE = 32'h0;
      end
    end
    mdOpE = 3'd0;
    @(negedge clk);
    busy_after = busyE;
    next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1; mdOpE = 3'd0; srcAE = '0; srcBE = '0; flushE = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stallE); end
    checks++;
    if (busyE !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busyE); end
    checks++;
    if (hiOut !== 32'h0 || loOut !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got %h_%h expected 0_0", hiOut, loOut);
    end
    next_cycle();
    $display("reset: hi=%h lo=%h", hiOut, loOut);
  endtask

  task automatic test_mt;
    logic stall_seen = 1'b0;
    mdOpE = 3'd5; srcAE = 32'h12345678;
    @(negedge clk);
    if (stallE !== 1'b0) stall_seen = 1'b1;
    next_cycle();
    mdOpE = 3'd6; srcAE = 32'hDEADBEEF;
    @(negedge clk);
    if (stallE !== 1'b0) stall_seen = 1'b1;
    checks++;
    if (hiOut !== 32'h12345678) begin errors++; $display("FAIL mthi: got %h expected 12345678", hiOut); end
    next_cycle();
    mdOpE = 3'd0;
    @(negedge clk);
    checks++;
    if (loOut !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo: got %h expected deadbeef", loOut); end
    checks++;
    if (stall_seen !== 1'b0) begin errors++; $display("FAIL mt_stall: got %b expected 0", stall_seen); end
    next_cycle();
    $display("mt: hi=%h lo=%h", hiOut, loOut);
  endtask

  task automatic test_mult;
    logic [2:0]  op [2] = '{3'd1, 3'd2};
    logic [31:0] a  [2] = '{32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [31:0] b  [2] = '{32'd3, 32'hFFFFFFFF};
    logic [31:0] eh [2] = '{32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] el [2] = '{32'hFFFFFFFA, 32'h00000001};
    int sc; logic sd, bm, ba; logic [31:0] h, l;
    for (int i = 0; i < 2; i++) begin
      run_op(op[i], a[i], b[i], 4, sc, sd, bm, ba, h, l);
      $display("mult op=%0d a=%h b=%h -> hi=%h lo=%h stall=%0d", op[i], a[i], b[i], h, l, sc);
      checks++;
      if (sc != 5) begin errors++; $display("FAIL mul_stall_cycles[%0d]: got %0d expected 5", i, sc); end
      checks++;
      if (sd !== 1'b0) begin errors++; $display("FAIL mul_done_stall[%0d]: got %b expected 0", i, sd); end
      checks++;
      if (bm !== 1'b1) begin errors++; $display("FAIL mul_busy[%0d]: got %b expected 1", i, bm); end
      checks++;
      if (ba !== 1'b0) begin errors++; $display("FAIL mul_reissue[%0d]: busy got %b expected 0", i, ba); end
      checks++;
      if (h !== eh[i] || l !== el[i]) begin
        errors++; $display("FAIL mul_result[%0d]: got %h_%h expected %h_%h", i, h, l, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div;
    int sc; logic sd, bm, ba; logic [31:0] h, l;
    for (int i = 0; i < 6; i++) begin
      run_op(div_op[i], div_a[i], div_b[i], 32, sc, sd, bm, ba, h, l);
      $display("div op=%0d a=%h b=%h -> hi=%h lo=%h stall=%0d", div_op[i], div_a[i], div_b[i], h, l, sc);
      checks++;
      if (sc != 33) begin errors++; $display("FAIL div_stall_cycles[%0d]: got %0d expected 33", i, sc); end
      checks++;
      if (sd !== 1'b0 || ba !== 1'b0) begin
        errors++; $display("FAIL div_done[%0d]: stall %b busy_after %b expected 0 0", i, sd, ba);
      end
      checks++;
      if (h !== div_hi[i] || l !== div_lo[i]) begin
        errors++; $display("FAIL div_result[%0d]: got %h_%h expected %h_%h", i, h, l, div_hi[i], div_lo[i]);
      end
    end
  endtask

  // HI/LO before this test hold FFFFFFFB / 00000001 from the last divide vector.
  task automatic test_flush;
    mdOpE = 3'd3; srcAE = 32'd100; srcBE = 32'd7;
    repeat (10) next_cycle();
    flushE = 1'b1;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stallE); end
    next_cycle();
    flushE = 1'b0; mdOpE = 3'd0;
    @(negedge clk);
    checks++;
    if (busyE !== 1'b0 || stallE !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy %b stall %b expected 0 0", busyE, stallE);
    end
    repeat (40) next_cycle();
    @(negedge clk);
    checks++;
    if (hiOut !== 32'hFFFFFFFB || loOut !== 32'h00000001) begin
      errors++; $display("FAIL flush_hold: got %h_%h expected fffffffb_00000001", hiOut, loOut);
    end
    next_cycle();
    flushE = 1'b1; mdOpE = 3'd5; srcAE = 32'hCAFEF00D;
    next_cycle();
    mdOpE = 3'd1;
    @(negedge clk);
    checks++;
    if (stallE !== 1'b0) begin errors++; $display("FAIL flush_idle_issue_stall: got %b expected 0", stallE); end
    next_cycle();
    flushE = 1'b0; mdOpE = 3'd0;
    @(negedge clk);
    checks++;
    if (busyE !== 1'b0 || hiOut !== 32'hFFFFFFFB) begin
      errors++; $display("FAIL flush_idle_block: busy %b hi %h expected 0 fffffffb", busyE, hiOut);
    end
    next_cycle();
    $display("flush: hi=%h lo=%h", hiOut, loOut);
  endtask

  task automatic test_rst_abort;
    mdOpE = 3'd3; srcAE = 32'd100; srcBE = 32'd7;
    repeat (10) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; mdOpE = 3'd0;
    @(negedge clk);
    checks++;
    if (busyE !== 1'b0 || hiOut !== 32'h0 || loOut !== 32'h0) begin
      errors++; $display("FAIL rst_abort: busy %b hilo %h_%h expected 0 0_0", busyE, hiOut, loOut);
    end
    repeat (40) next_cycle();
    @(negedge clk);
    checks++;
    if (hiOut !== 32'h0 || loOut !== 32'h0) begin
      errors++; $display("FAIL rst_abort_late: got %h_%h expected 0_0", hiOut, loOut);
    end
    next_cycle();
    $display("rst_abort: hi=%h lo=%h", hiOut, loOut);
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_flush();
    test_rst_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
